// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: stage-register load/kill strobes,
// once-per-instruction cache handshakes and saturating performance counters.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_resp,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        dmem_resp,
    input  logic        load_use_hazard,
    input  logic        branch_taken,
    input  logic        perf_clear,
    output logic        imem_read,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        load_pc,
    output logic        pc_sel_target,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        kill_if_id,
    output logic        kill_id_ex,
    output logic        kill_ex_mem,
    output logic [15:0] perf_istall,
    output logic [15:0] perf_dstall,
    output logic [15:0] perf_bubble,
    output logic [15:0] perf_flush
);

    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [15:0] istall_cnt_d, dstall_cnt_d, bubble_cnt_d, flush_cnt_d;
    logic        mem_access, istall, dstall, stall, do_branch, do_bubble;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
        return (inc && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            perf_istall <= 16'd0;
            perf_dstall <= 16'd0;
            perf_bubble <= 16'd0;
            perf_flush  <= 16'd0;
        end else begin
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            perf_istall <= istall_cnt_d;
            perf_dstall <= dstall_cnt_d;
            perf_bubble <= bubble_cnt_d;
            perf_flush  <= flush_cnt_d;
        end
    end

    always_comb begin
        mem_access = mem_valid & (mem_read | mem_write);
        istall     = ~i_done_q & ~imem_resp;
        dstall     = mem_access & ~d_done_q & ~dmem_resp;
        stall      = istall | dstall;
        do_branch  = ~stall & branch_taken;
        do_bubble  = ~stall & ~branch_taken & load_use_hazard;

        // A bubble holds the PC, so the fetch already completed must be remembered.
        if (stall || do_bubble) begin
            i_done_d = i_done_q | imem_resp;
        end else begin
            i_done_d = 1'b0;
        end
        d_done_d = stall ? (d_done_q | (dmem_resp & mem_access)) : 1'b0;

        if (perf_clear) begin
            istall_cnt_d = 16'd0;
            dstall_cnt_d = 16'd0;
            bubble_cnt_d = 16'd0;
            flush_cnt_d  = 16'd0;
        end else begin
            istall_cnt_d = sat_inc(perf_istall, istall);
            dstall_cnt_d = sat_inc(perf_dstall, dstall);
            bubble_cnt_d = sat_inc(perf_bubble, do_bubble);
            flush_cnt_d  = sat_inc(perf_flush, do_branch);
        end
    end

    // Outputs are forced low while reset is held, regardless of inputs.
    always_comb begin
        imem_read     = ~reset & ~i_done_q;
        dmem_read     = ~reset & mem_valid & mem_read & ~d_done_q;
        dmem_write    = ~reset & mem_valid & mem_write & ~d_done_q;
        load_pc       = 1'b0;
        pc_sel_target = 1'b0;
        load_if_id    = 1'b0;
        load_id_ex    = 1'b0;
        load_ex_mem   = 1'b0;
        load_mem_wb   = 1'b0;
        kill_if_id    = 1'b0;
        kill_id_ex    = 1'b0;
        kill_ex_mem   = 1'b0;
        if (!reset && !stall) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (do_branch) begin
                load_pc       = 1'b1;
                pc_sel_target = 1'b1;
                load_if_id    = 1'b1;
                kill_if_id    = 1'b1;
                kill_id_ex    = 1'b1;
                kill_ex_mem   = 1'b1;
            end else if (do_bubble) begin
                kill_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expected strobes go through a scoreboard
// queue; counters are checked against hand-derived totals.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_resp, mem_valid, mem_read, mem_write, dmem_resp;
    logic        load_use_hazard, branch_taken, perf_clear;
    logic        imem_read, dmem_read, dmem_write, load_pc, pc_sel_target;
    logic        load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        kill_if_id, kill_id_ex, kill_ex_mem;
    logic [15:0] perf_istall, perf_dstall, perf_bubble, perf_flush;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          step     = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got_vec;

    localparam int KStall  = 0;
    localparam int KNormal = 1;
    localparam int KBranch = 2;
    localparam int KBubble = 3;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .imem_resp       (imem_resp),
        .mem_valid       (mem_valid),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .dmem_resp       (dmem_resp),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .perf_clear      (perf_clear),
        .imem_read       (imem_read),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .load_pc         (load_pc),
        .pc_sel_target   (pc_sel_target),
        .load_if_id      (load_if_id),
        .load_id_ex      (load_id_ex),
        .load_ex_mem     (load_ex_mem),
        .load_mem_wb     (load_mem_wb),
        .kill_if_id      (kill_if_id),
        .kill_id_ex      (kill_id_ex),
        .kill_ex_mem     (kill_ex_mem),
        .perf_istall     (perf_istall),
        .perf_dstall     (perf_dstall),
        .perf_bubble     (perf_bubble),
        .perf_flush      (perf_flush)
    );

    assign got_vec = {imem_read, dmem_read, dmem_write, load_pc, pc_sel_target, load_if_id,
                      load_id_ex, load_ex_mem, load_mem_wb, kill_if_id, kill_id_ex, kill_ex_mem};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Layout: {load_pc, pc_sel_target, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, kills}
    function automatic logic [11:0] exp_vec(input logic ir, input logic dr, input logic dw,
                                            input int kind);
        logic [8:0] ctl;
        case (kind)
            KNormal: ctl = 9'b101111000;
            KBranch: ctl = 9'b111111111;
            KBubble: ctl = 9'b000111010;
            default: ctl = 9'b000000000;
        endcase
        return {ir, dr, dw, ctl};
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input logic ir_resp, input logic mv, input logic mr, input logic mw,
                       input logic dr_resp, input logic lu, input logic bt, input logic pc,
                       input logic e_ir, input logic e_dr, input logic e_dw, input int kind);
        logic [11:0] e;
        imem_resp       = ir_resp;
        mem_valid       = mv;
        mem_read        = mr;
        mem_write       = mw;
        dmem_resp       = dr_resp;
        load_use_hazard = lu;
        branch_taken    = bt;
        perf_clear      = pc;
        exp_q.push_back(exp_vec(e_ir, e_dr, e_dw, kind));
        #2;
        e = exp_q.pop_front();
        check($sformatf("strobes step %0d", step), {20'd0, got_vec}, {20'd0, e});
        step++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] ei, input logic [15:0] ed,
                             input logic [15:0] eb, input logic [15:0] ef);
        check({tag, " istall"}, {16'd0, perf_istall}, {16'd0, ei});
        check({tag, " dstall"}, {16'd0, perf_dstall}, {16'd0, ed});
        check({tag, " bubble"}, {16'd0, perf_bubble}, {16'd0, eb});
        check({tag, " flush"},  {16'd0, perf_flush},  {16'd0, ef});
    endtask

    initial begin
        reset = 1'b1;
        imem_resp = 1'b1; mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
        dmem_resp = 1'b0; load_use_hazard = 1'b1; branch_taken = 1'b1; perf_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("reset strobes", {20'd0, got_vec}, 32'd0);
        check_cnt("reset", 16'd0, 16'd0, 16'd0, 16'd0);
        reset = 1'b0;

        // Single-cycle hits
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, KNormal);
        check_cnt("hits", 16'd0, 16'd0, 16'd0, 16'd0);

        // I-miss for 3 cycles
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, KStall);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, KNormal);
        check_cnt("imiss", 16'd3, 16'd0, 16'd0, 16'd0);

        // Clear during an istall cycle: clear wins; fetch still outstanding afterwards
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, KStall);
        check_cnt("clear", 16'd0, 16'd0, 16'd0, 16'd0);

        // Overlapping misses: load in MEM, dmem_resp at cycle 2, imem_resp at cycle 5
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, KStall);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, KStall);
        cyc(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, KStall);
        cyc(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, KStall);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, KStall);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, KNormal);
        check_cnt("overlap", 16'd5, 16'd2, 16'd0, 16'd0);

        // Taken branch held while a store D-stalls for 2 cycles
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, KNormal);
        cyc(1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, KStall);
        cyc(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, KStall);
        cyc(1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, KBranch);
        check_cnt("branch", 16'd0, 16'd2, 16'd0, 16'd1);

        // Load-use alone, then load-use with branch (branch wins)
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, KBubble);
        check_cnt("bubble", 16'd0, 16'd2, 16'd1, 16'd1);
        cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, KBranch);
        check_cnt("lu+br", 16'd0, 16'd2, 16'd1, 16'd2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, KNormal);

        // Saturation: 70000 istall cycles
        imem_resp = 1'b0; mem_valid = 1'b0; load_use_hazard = 1'b0; branch_taken = 1'b0;
        perf_clear = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("sat istall", {16'd0, perf_istall}, 32'h0000FFFF);

        // Clear together with an increment
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, KStall);
        check_cnt("sat clear", 16'd0, 16'd0, 16'd0, 16'd0);

        // Reset mid-miss drops the request at once
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, KStall);
        #2 reset = 1'b1;
        #1;
        check("reset imem_read", {31'd0, imem_read}, 32'd0);
        check("reset mid strobes", {20'd0, got_vec}, 32'd0);
        check_cnt("reset mid", 16'd0, 16'd0, 16'd0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, KStall);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, KNormal);
        check_cnt("post reset", 16'd1, 16'd0, 16'd0, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage LC-3b pipeline. Generates the load and valid-kill strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC. Sequences the instruction-cache and data-cache handshakes so each access is issued exactly once per instruction. Keeps saturating stall/flush performance counters.

## Interface
- No parameters; counter width fixed at 16.
- clk  in  1  single pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_resp  in  1  I-cache response for current fetch
- mem_valid  in  1  valid bit of EX/MEM register output
- mem_read  in  1  MEM-stage instruction is a load (from control word)
- mem_write  in  1  MEM-stage instruction is a store (from control word)
- dmem_resp  in  1  D-cache response
- load_use_hazard  in  1  decode detects a dependence on the load in EX
- branch_taken  in  1  MEM stage resolved a taken branch/jump (already qualified by mem_valid)
- perf_clear  in  1  synchronous clear of all counters
- imem_read  out  1  I-cache read request, held until response
- dmem_read  out  1  D-cache read request, held until response
- dmem_write  out  1  D-cache write request, held until response
- load_pc  out  1  PC register load
- pc_sel_target  out  1  1 = PC loads branch target, 0 = PC+2
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage register loads
- kill_if_id, kill_id_ex, kill_ex_mem  out  1 each  when set with matching load, stage captures valid=0
- perf_istall, perf_dstall, perf_bubble, perf_flush  out  16 each  event counters

## Operation
- State: i_done (fetch of current PC complete), d_done (MEM access of current instruction complete), four counters.
- mem_access = mem_valid & (mem_read | mem_write).
- imem_read = ~i_done. dmem_read = mem_valid & mem_read & ~d_done. dmem_write = mem_valid & mem_write & ~d_done.
- istall = ~i_done & ~imem_resp. dstall = mem_access & ~d_done & ~dmem_resp. stall = istall | dstall.
- advance = ~stall. On advance: i_done and d_done clear to 0.
- While stall: i_done sets when imem_resp; d_done sets when dmem_resp with mem_access. Flags hold until advance. The cache is never re-requested for the same instruction.
- Priority when advancing: branch_taken > load_use_hazard > normal.
- Normal advance: load_pc and all four load_* = 1. pc_sel_target = 0. All kills = 0.
- Branch advance:
  - load_pc = 1 and pc_sel_target = 1.
  - All loads = 1.
  - kill_if_id, kill_id_ex and kill_ex_mem = 1.
  - MEM/WB captures the branch itself.
- Load-use bubble (no branch):
  - load_pc = 0 and load_if_id = 0; PC and IF/ID hold.
  - load_id_ex = 1 with kill_id_ex = 1.
  - load_ex_mem = 1 and load_mem_wb = 1.
  - i_done is not cleared: it keeps its value, or sets if imem_resp this cycle.
- Stall: every load_* = 0, every kill = 0, load_pc = 0. A pending branch or hazard waits; it is acted on in the cycle the stall clears.
- Counters (16-bit, saturate at 0xFFFF, no wrap):
  - perf_istall +1 per cycle with istall.
  - perf_dstall +1 per cycle with dstall. Both count if both stalls are active.
  - perf_bubble +1 per load-use bubble cycle.
  - perf_flush +1 per branch advance.
  - perf_clear zeroes all counters and wins over a same-cycle increment.

## Timing
- All request, load and kill outputs are combinational from inputs and state; no added latency.
- An I-cache or D-cache response in the same cycle as the request lets the pipeline advance that cycle.
- While reset is high:
  - All outputs are 0: requests, loads, kills, pc_sel_target and counters.
  - i_done = d_done = 0.
- On the first cycle after reset deassertion, imem_read = 1.
- Reset mid-access drops the request immediately; no state is kept.
- A response arriving with no outstanding request (flag already set) is ignored.
- If both caches stall and respond in different cycles, the pipeline advances only in the cycle the later response arrives or after it.

## Test plan
- Single-cycle hits: imem_resp = 1 every cycle and no mem ops → all loads = 1 each cycle. Counters stay 0.
- I-miss: imem_resp low for 3 cycles, then high → loads = 0 for 3 cycles and advance on the 4th. perf_istall = 3.
- Overlapping misses: a load in MEM with dmem_resp at cycle 2 and imem_resp at cycle 5 → dmem_read drops after cycle 2 and is not reissued. Advance at cycle 5. perf_dstall = 2 and perf_istall = 5.
- Taken branch during a D-stall: branch_taken held while dstall lasts 2 cycles → no load for 2 cycles. Then one cycle with pc_sel_target = 1 and three kills = 1. perf_flush = 1.
- Load-use combined with branch: load_use_hazard = 1 alone → load_pc = 0, load_if_id = 0, kill_id_ex = 1 and perf_bubble +1. The same cycle with branch_taken = 1 → branch behaviour only.
- Counter limits: force 70000 istall cycles → perf_istall = 0xFFFF. perf_clear together with an increment → 0. Reset asserted mid-miss → imem_read = 0 immediately.
